tile_read_streamer: RTL

Address generator and read streamer that sits directly upstream of the compute datapath and downstream of the team's multi-port scratchpad memory. On a start command it walks a strided sequence of beats through the memory. Each beat drives `NumPorts` consecutive addresses, one per memory port, and returns the combinational read data through a registered valid/ready output stage toward the PE array. It never writes the memory.

---
 rtl/tile_read_streamer_if.sv | 31 +++
 rtl/tile_read_streamer.sv | 95 +++++++++
 2 files changed

// File: rtl/tile_read_streamer_if.sv
// Scratchpad read-port bus plus the valid/ready beat stream toward the PE array.
// Purely structural: no logic, so it adds no latency and no backpressure of its own.
interface tile_read_streamer_if #(
  parameter int DataWidth = 8,
  parameter int NumPorts  = 4,
  parameter int AddrWidth = 12
);
  logic        [NumPorts-1:0][AddrWidth-1:0] mem_addr_o;
  logic        [NumPorts-1:0]                mem_we_o;
  logic        [NumPorts-1:0][DataWidth-1:0] mem_wr_data_o;
  logic signed [NumPorts-1:0][DataWidth-1:0] mem_rd_data_i;
  logic                                      out_valid_o;
  logic                                      out_ready_i;
  logic signed [NumPorts-1:0][DataWidth-1:0] out_data_o;

  modport master (
    output mem_addr_o, mem_we_o, mem_wr_data_o,
    input  mem_rd_data_i,
    output out_valid_o,
    input  out_ready_i,
    output out_data_o
  );

  modport slave (
    input  mem_addr_o, mem_we_o, mem_wr_data_o,
    output mem_rd_data_i,
    input  out_valid_o,
    output out_ready_i,
    input  out_data_o
  );
endinterface

// File: rtl/tile_read_streamer.sv
// Strided multi-port scratchpad reader: first beat 2 cycles after start, then 1 beat/cycle.
// Output register holds beat and stalls address walk while out_ready_i is low.
module tile_read_streamer #(
  parameter int DataWidth  = 8,
  parameter int NumPorts   = 4,
  parameter int AddrWidth  = 12,
  parameter int CountWidth = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [AddrWidth-1:0]  base_addr_i,
  input  logic [AddrWidth-1:0]  stride_i,
  input  logic [CountWidth-1:0] num_beats_i,
  output logic                  busy_o,
  output logic                  done_o,
  tile_read_streamer_if.master  io
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                                    state_q;
  logic        [AddrWidth-1:0]               beat_addr_q;
  logic        [AddrWidth-1:0]               stride_q;
  logic        [CountWidth-1:0]              remaining_q;
  logic                                      out_valid_q;
  logic                                      done_q;
  logic signed [NumPorts-1:0][DataWidth-1:0] out_data_q;
  logic                                      can_load;

  // The output register may refill on the same edge it hands a beat off.
  assign can_load = !out_valid_q || io.out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      beat_addr_q <= '0;
      stride_q    <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (num_beats_i != '0) begin
              beat_addr_q <= base_addr_i;
              stride_q    <= stride_i;
              remaining_q <= num_beats_i;
              state_q     <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (can_load) begin
            out_data_q  <= io.mem_rd_data_i;
            out_valid_q <= 1'b1;
            beat_addr_q <= beat_addr_q + stride_q;
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == CountWidth'(1)) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_valid_q && io.out_ready_i) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Port p reads the word p places above the beat address, wrapping modulo 2^AddrWidth.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      io.mem_addr_o[p] = beat_addr_q + AddrWidth'(p);
    end
  end

  assign io.mem_we_o      = '0;
  assign io.mem_wr_data_o = '0;
  assign io.out_valid_o   = out_valid_q;
  assign io.out_data_o    = out_data_q;
  assign busy_o           = (state_q != IDLE);
  assign done_o           = done_q;

endmodule
